// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment controller: per-digit hex/dp/blank storage written on a rising edge of en,
// scanned one digit per CLK_DIV clocks with a one-clock all-off gap; outputs registered, optional inversion.
module seg_scan_display #(
  parameter int DIGITS     = 8,
  parameter int SEL_W      = 3,
  parameter int CLK_DIV    = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        input_data,
  input  logic              dp_in,
  input  logic              blank_in,
  input  logic [SEL_W-1:0]  select,
  input  logic              clr,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int              PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);
  localparam logic            POL      = (ACTIVE_LOW != 0);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  logic                   en_d_q, en_d_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [SEL_W-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0][3:0] val_q, val_d;
  logic [DIGITS-1:0]      dpm_q, dpm_d;
  logic [DIGITS-1:0]      blank_q, blank_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [DIGITS-1:0]      sel_q, sel_d;
  logic                   wr;
  logic [3:0]             cur_val;
  logic                   cur_dp, cur_blank;

  always_comb begin
    wr        = en & ~en_d_q;
    en_d_d    = en;
    presc_d   = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (presc_q == PRE_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    val_d     = val_q;
    dpm_d     = dpm_q;
    blank_d   = blank_q;
    cur_val   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    // Out-of-range selects match no entry, so such writes fall through untouched.
    for (int i = 0; i < DIGITS; i++) begin
      if (clr) begin
        val_d[i]   = 4'h0;
        dpm_d[i]   = 1'b0;
        blank_d[i] = 1'b1;
      end else if (wr && select == SEL_W'(i)) begin
        val_d[i]   = input_data;
        dpm_d[i]   = dp_in;
        blank_d[i] = blank_in;
      end
      if (idx_q == SEL_W'(i)) begin
        cur_val   = val_q[i];
        cur_dp    = dpm_q[i];
        cur_blank = blank_q[i];
      end
    end
    seg_d = (cur_blank ? 7'b0000000 : hex7(cur_val)) ^ {7{POL}};
    dp_d  = (cur_dp & ~cur_blank) ^ POL;
    for (int i = 0; i < DIGITS; i++) begin
      sel_d[i] = ((presc_q != '0) && (idx_q == SEL_W'(i))) ^ POL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_d_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dpm_q   <= '0;
      blank_q <= '1;
      seg_q   <= {7{POL}};
      dp_q    <= POL;
      sel_q   <= {DIGITS{POL}};
    end else begin
      en_d_q  <= en_d_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dpm_q   <= dpm_d;
      blank_q <= blank_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: an active-high and an active-low instance share stimulus and are
// compared every cycle against a frame-position/contents model derived from the display rules.
module tb_seg_scan_display;
  localparam int DIGITS  = 8;
  localparam int SEL_W   = 4;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, dp_in = 1'b0, blank_in = 1'b0, clr = 1'b0;
  logic [3:0] input_data = 4'h0;
  logic [SEL_W-1:0] select = '0;
  logic [6:0] seg_h, seg_l;
  logic dp_h, dp_l;
  logic [DIGITS-1:0] sel_h, sel_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_display #(.DIGITS(DIGITS), .SEL_W(SEL_W), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst(rst), .en(en), .input_data(input_data), .dp_in(dp_in), .blank_in(blank_in),
    .select(select), .clr(clr), .seg(seg_h), .dp(dp_h), .digit_sel(sel_h));

  seg_scan_display #(.DIGITS(DIGITS), .SEL_W(SEL_W), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst(rst), .en(en), .input_data(input_data), .dp_in(dp_in), .blank_in(blank_in),
    .select(select), .clr(clr), .seg(seg_l), .dp(dp_l), .digit_sel(sel_l));

  // Reference model: display contents plus elapsed clocks since reset release.
  logic [6:0] dec_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [3:0] m_val [DIGITS];
  logic m_dp [DIGITS];
  logic m_blank [DIGITS];
  logic m_en_prev;
  int t, slot, dig;
  logic [6:0] exp_seg;
  logic exp_dp;
  logic [DIGITS-1:0] exp_sel;
  logic [15:0] exp_h, exp_l;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t = 0;
      m_en_prev = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        m_val[i] = 4'h0; m_dp[i] = 1'b0; m_blank[i] = 1'b1;
      end
      exp_seg = 7'h0; exp_dp = 1'b0; exp_sel = '0;
    end else begin
      slot = t % CLK_DIV;
      dig  = (t / CLK_DIV) % DIGITS;
      exp_sel = '0;
      if (slot != 0) exp_sel[dig] = 1'b1;
      exp_seg = m_blank[dig] ? 7'h0 : dec_tab[m_val[dig]];
      exp_dp  = !m_blank[dig] && m_dp[dig];
      if (clr) begin
        for (int i = 0; i < DIGITS; i++) begin
          m_val[i] = 4'h0; m_dp[i] = 1'b0; m_blank[i] = 1'b1;
        end
      end else if (en && !m_en_prev && int'(select) < DIGITS) begin
        m_val[select] = input_data; m_dp[select] = dp_in; m_blank[select] = blank_in;
      end
      m_en_prev = en;
      t++;
    end
    exp_h = {exp_seg, exp_dp, exp_sel};
    exp_l = ~exp_h;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      en = ~en; select = SEL_W'($urandom_range(0, 7)); input_data = 4'($urandom);
      #1;
      checks++;
      if ({seg_h, dp_h, sel_h, seg_l, dp_l, sel_l} !== {7'h00, 1'b0, 8'h00, 7'h7f, 1'b1, 8'hff}) begin
        failures++;
        $display("FAIL reset_idle: got h=%b/%b/%b l=%b/%b/%b required h all 0, l all 1",
                 seg_h, dp_h, sel_h, seg_l, dp_l, sel_l);
      end
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= DIGITS * CLK_DIV + 2; c++) begin
      @(negedge clk);
      checks++;
      if ({seg_h, dp_h, sel_h, seg_l, dp_l, sel_l} !== {exp_h, exp_l}) begin
        failures++;
        $display("FAIL reset_frame c=%0d: got h=%b/%b/%b l=%b/%b/%b required h=%b l=%b",
                 c, seg_h, dp_h, sel_h, seg_l, dp_l, sel_l, exp_h, exp_l);
      end
      checks++;
      if (seg_h !== 7'h00 || (c == 1 && sel_h !== 8'h00) || (c == 2 && sel_h !== 8'h01)) begin
        failures++;
        $display("FAIL reset_blank c=%0d: got seg=%b sel=%b required seg=0000000, sel 0 then 1", c, seg_h, sel_h);
      end
    end
  endtask

  task automatic test_write_sweep();
    for (int i = 0; i < 2 * DIGITS + DIGITS * CLK_DIV * 2; i++) begin
      @(negedge clk);
      checks++;
      if ({seg_h, dp_h, sel_h, seg_l, dp_l, sel_l} !== {exp_h, exp_l}) begin
        failures++;
        $display("FAIL sweep i=%0d: got h=%b/%b/%b l=%b/%b/%b required h=%b l=%b",
                 i, seg_h, dp_h, sel_h, seg_l, dp_l, sel_l, exp_h, exp_l);
      end
      if (sel_h == 8'h01 || sel_h == 8'h80) begin
        checks++;
        if (seg_h !== ((sel_h == 8'h01) ? 7'b0110000 : 7'b1111111) && i > 2 * DIGITS + 1) begin
          failures++;
          $display("FAIL sweep_pattern sel=%b: got seg=%b", sel_h, seg_h);
        end
      end
      if (i < 2 * DIGITS) begin
        en = (i % 2 == 0);
        select = SEL_W'(i / 2); input_data = 4'(i / 2 + 1); dp_in = 1'b0; blank_in = 1'b0;
      end else en = 1'b0;
    end
  endtask

  task automatic test_edge_detect();
    for (int i = 0; i < 16 + DIGITS * CLK_DIV; i++) begin
      @(negedge clk);
      checks++;
      if ({seg_h, dp_h, sel_h, seg_l, dp_l, sel_l} !== {exp_h, exp_l}) begin
        failures++;
        $display("FAIL edge i=%0d: got h=%b/%b/%b l=%b/%b/%b required h=%b l=%b",
                 i, seg_h, dp_h, sel_h, seg_l, dp_l, sel_l, exp_h, exp_l);
      end
      if (sel_h == 8'h08 && i > 16) begin
        checks++;
        if (seg_h !== 7'b1111001) begin
          failures++;
          $display("FAIL edge_hold: got seg=%b required 1111001", seg_h);
        end
      end
      en = (i < 10) || (i == 12);
      select = (i < 10) ? SEL_W'(3) : SEL_W'(9);
      input_data = (i < 3) ? 4'h3 : (i < 6) ? 4'h5 : 4'h9;
    end
    en = 1'b0;
  endtask

  task automatic test_blank_dp();
    for (int i = 0; i < 4 + 2 * DIGITS * CLK_DIV; i++) begin
      @(negedge clk);
      checks++;
      if ({seg_h, dp_h, sel_h, seg_l, dp_l, sel_l} !== {exp_h, exp_l}) begin
        failures++;
        $display("FAIL blank_dp i=%0d: got h=%b/%b/%b l=%b/%b/%b required h=%b l=%b",
                 i, seg_h, dp_h, sel_h, seg_l, dp_l, sel_l, exp_h, exp_l);
      end
      if (sel_h == 8'h04 && i > 2 && i < 2 + DIGITS * CLK_DIV) begin
        checks++;
        if ({seg_h, dp_h} !== {7'b1111111, 1'b1}) begin
          failures++;
          $display("FAIL dp_digit2: got seg=%b dp=%b required 1111111 1", seg_h, dp_h);
        end
      end
      if (i > 4 + DIGITS * CLK_DIV) begin
        checks++;
        if ({seg_h, dp_h} !== 8'h00) begin
          failures++;
          $display("FAIL clr_blank: got seg=%b dp=%b required 0000000 0", seg_h, dp_h);
        end
      end
      en = (i == 0) || (i == 2 + DIGITS * CLK_DIV);
      clr = (i == 2 + DIGITS * CLK_DIV);
      select = SEL_W'(2); input_data = 4'h8; dp_in = 1'b1; blank_in = 1'b0;
    end
    clr = 1'b0; dp_in = 1'b0;
  endtask

  task automatic test_polarity();
    for (int i = 0; i < 2 + 2 * DIGITS * CLK_DIV; i++) begin
      @(negedge clk);
      checks++;
      if ({seg_h, dp_h, sel_h, seg_l, dp_l, sel_l} !== {exp_h, exp_l}) begin
        failures++;
        $display("FAIL polarity i=%0d: got h=%b/%b/%b l=%b/%b/%b required h=%b l=%b",
                 i, seg_h, dp_h, sel_h, seg_l, dp_l, sel_l, exp_h, exp_l);
      end
      if (sel_l == 8'hfe && i > 2) begin
        checks++;
        if ({seg_l, dp_l} !== {7'b0000001, 1'b1}) begin
          failures++;
          $display("FAIL polarity_digit0: got seg=%b dp=%b required 0000001 1", seg_l, dp_l);
        end
      end
      en = (i == 0); select = '0; input_data = 4'h0; dp_in = 1'b0; blank_in = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if ({seg_h, dp_h, sel_h, seg_l, dp_l, sel_l} !== {exp_h, exp_l}) begin
        failures++;
        $display("FAIL random i=%0d: got h=%b/%b/%b l=%b/%b/%b required h=%b l=%b",
                 i, seg_h, dp_h, sel_h, seg_l, dp_l, sel_l, exp_h, exp_l);
      end
      en = ($urandom_range(0, 2) == 0);
      select = SEL_W'($urandom_range(0, 15));
      input_data = 4'($urandom);
      dp_in = 1'($urandom);
      blank_in = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 60) == 0);
    end
    en = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int i = 0; i < 3 * DIGITS * CLK_DIV; i++) begin
      @(negedge clk);
      if (sel_h == 8'h20) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid_wait: digit 5 never selected, got sel=%b", sel_h);
    end
    en = 1'b1; select = SEL_W'(1); input_data = 4'h7; blank_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({seg_h, dp_h, sel_h, seg_l, dp_l, sel_l} !== {7'h00, 1'b0, 8'h00, 7'h7f, 1'b1, 8'hff}) begin
      failures++;
      $display("FAIL reset_mid_async: got h=%b/%b/%b l=%b/%b/%b required h all 0, l all 1",
               seg_h, dp_h, sel_h, seg_l, dp_l, sel_l);
    end
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= DIGITS * CLK_DIV + 2; c++) begin
      @(negedge clk);
      checks++;
      if ({seg_h, dp_h, sel_h, seg_l, dp_l, sel_l} !== {exp_h, exp_l} || seg_h !== 7'h00 ||
          (c == 2 && sel_h !== 8'h01)) begin
        failures++;
        $display("FAIL reset_mid_resume c=%0d: got h=%b/%b/%b l=%b/%b/%b required h=%b (blank, digit 0 first)",
                 c, seg_h, dp_h, sel_h, seg_l, dp_l, sel_l, exp_h);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_sweep();
    test_edge_detect();
    test_blank_dp();
    test_polarity();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment display controller for the board's LED digit bank. It holds one 4-bit hex value, a decimal-point bit and a blank flag per digit, written through a strobe/select port. It time-multiplexes the digits with a programmable scan rate, a ghost-suppression gap and selectable output polarity. It supersedes the fixed 8-digit display block and sits between the user-logic register interface and the segment/digit-select pins.

## Interface
- DIGITS, 8, number of digits scanned (2..16)
- SEL_W, 3, width of select; must satisfy 2^SEL_W >= DIGITS
- CLK_DIV, 4, clocks each digit stays selected, including the gap cycle (>= 2)
- ACTIVE_LOW, 0, 1 inverts seg, dp and digit_sel (common-anode boards)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  write strobe; rising-edge detected internally
- input_data  in  4  hex value to store
- dp_in  in  1  decimal-point bit to store
- blank_in  in  1  1 = store the digit as blank
- select  in  SEL_W  target digit index
- clr  in  1  synchronous clear; blanks all digits
- seg  out  7  segments {a,b,c,d,e,f,g}, registered
- dp  out  1  decimal point, registered
- digit_sel  out  DIGITS  one-hot digit enable, registered; bit i drives digit i

## Operation
- Edge detect: en_d is en delayed by one clock. A write occurs on an edge where en=1 and en_d=0. Holding en high writes exactly once.
- Write: stores {input_data, dp_in, blank_in} into entry select.
- select >= DIGITS: the write is ignored and no entry changes.
- clr=1: sets every entry to value 0, dp 0, blank 1. When clr and a write occur in the same cycle, clr wins.
- Scan: a prescaler counts 0..CLK_DIV-1. On terminal count it returns to 0 and the digit index advances. The index wraps DIGITS-1 -> 0.
- Gap: while prescaler = 0, digit_sel is all inactive (ghost suppression). Otherwise only bit index is active.
- Decode, active-high abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Blank entry: seg=0000000 and dp=0, active-high sense.
- ACTIVE_LOW=1: seg, dp and digit_sel are bitwise inverted at the output registers.

## Timing
- Reset, asserted asynchronously:
  - all entries value 0, dp 0, blank 1
  - index 0, prescaler 0, en_d 0
  - seg, dp and digit_sel inactive: all 0, or all 1 if ACTIVE_LOW
- First cycles after reset release: digit_sel stays inactive for the first clock, then digit 0 turns on. Outputs show blank until written.
- Output latency: seg, dp and digit_sel are registered from the current index, prescaler and storage. A store or index change appears on the outputs one clock later.
- Write to the displayed digit: the new pattern appears on the edge after the storage edge, with no tearing.
- Scan period per digit: exactly CLK_DIV clocks, of which 1 is the gap. Full frame = DIGITS*CLK_DIV clocks.
- Reset mid-scan or mid-write: all outputs go inactive immediately and no partial write is retained. Scan restarts at digit 0.
- Writes and clr have no effect on prescaler or index.

## Test plan
- Reset: hold rst=0 for 2 clocks with en toggling -> digit_sel=0, seg=0, dp=0, and no writes after release. Release, then run a full frame -> seg=0 at every digit.
- Write sweep (DIGITS=8, CLK_DIV=4): write value i+1 to digit i for i=0..7, each via a 1-clock en pulse. Over one frame, digit_sel one-hot i shows the decode of i+1 (digit 0 shows 0110000, digit 7 shows 1111111), with a 1-cycle all-off gap before each digit.
- Edge detect: hold en=1 for 10 clocks while input_data changes 3 -> 5 -> 9 -> digit keeps 3 (1111001). Then select=9 with DIGITS=8 and pulse en -> no entry changes.
- Blank/dp: write value 8 with dp_in=1 to digit 2 -> seg=1111111, dp=1 at digit 2. Pulse clr in the same cycle as an en pulse -> all digits blank.
- Polarity (ACTIVE_LOW=1): write 0 to digit 0 -> seg=0000001, digit_sel=11111110 during its slot, and all 1s during gaps and reset.
- Reset mid-frame: assert rst at index 5 -> outputs inactive within the same cycle. After release, scan resumes at digit 0 with blank contents.
